if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_pkg.sv | 6 +
 rtl/imem_bank.sv | 27 ++
 rtl/if_fetch_unit.sv | 87 ++++++++
 tb/tb_if_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch slice: NOP encoding, default width, PC stride.
package if_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam int          XLEN_DEFAULT = 32;
  localparam int          PC_INC       = 4;
endpackage

// File: rtl/imem_bank.sv
// Instruction memory: one synchronous write port, one combinational read port.
// A read of the word being written this cycle returns the old contents.
module imem_bank
  import if_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  // Power-up contents are NOP; reset deliberately does not touch the array.
  logic [31:0] r_mem [DEPTH] = '{default: NOP_INSTR};

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC register, instruction memory lookup and IF/ID pipeline register.
// Priority per edge is reset, then redirect (flushes IF/ID), then stall (holds), then pc+4.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter int              IMEM_DEPTH = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [XLEN-1:0]               branch_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               ifid_pc,
  output logic [31:0]                   ifid_instr,
  output logic                          ifid_valid,
  output logic                          fetch_oob,
  output logic                          misalign_err
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;
  logic            r_misalign;

  logic [XLEN-1:0] w_word_idx;
  logic [XLEN-1:0] w_target;
  logic [31:0]     w_mem_word;
  logic [31:0]     w_fetch_word;
  logic            w_oob;

  assign w_word_idx   = r_pc >> 2;
  assign w_oob        = (w_word_idx >= XLEN'(IMEM_DEPTH));
  assign w_target     = {branch_target[XLEN-1:2], 2'b00};
  assign w_fetch_word = w_oob ? NOP_INSTR : w_mem_word;

  imem_bank #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (r_pc[AW+1:2]),
    .rdata (w_mem_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall; the wrong-path fetch is squashed into a bubble.
      r_pc         <= w_target;
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      if (|branch_target[1:0]) begin
        r_misalign <= 1'b1;
      end
    end else if (!stall) begin
      r_pc         <= r_pc + XLEN'(PC_INC);
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= w_fetch_word;
      r_ifid_valid <= 1'b1;
    end
  end

  assign pc           = r_pc;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_instr   = r_ifid_instr;
  assign ifid_valid   = r_ifid_valid;
  assign fetch_oob    = w_oob;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table for the main flow plus hand sequences
// for sticky misalign, same-cycle write/read, asynchronous reset and post-reset refetch.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_oob;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit #(
    .XLEN       (32),
    .IMEM_DEPTH (32),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .pc            (pc),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .fetch_oob     (fetch_oob),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_vld;
    logic        e_oob;
    logic        e_mis;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                         input logic [31:0] e_instr, input logic e_vld, input logic e_oob,
                         input logic e_mis);
    chk({nm, ".pc"},       pc,                   e_pc);
    chk({nm, ".ifid_pc"},  ifid_pc,              e_ifpc);
    chk({nm, ".instr"},    ifid_instr,           e_instr);
    chk({nm, ".valid"},    {31'b0, ifid_valid},  {31'b0, e_vld});
    chk({nm, ".oob"},      {31'b0, fetch_oob},   {31'b0, e_oob});
    chk({nm, ".misalign"}, {31'b0, misalign_err}, {31'b0, e_mis});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    step();
    imem_we    = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"fetch0",    1'b0, 1'b0, 32'h0,  32'h04, 32'h00, 32'h00500093, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"fetch1",    1'b0, 1'b0, 32'h0,  32'h08, 32'h04, 32'h00500113, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{"stall1",    1'b1, 1'b0, 32'h0,  32'h08, 32'h04, 32'h00500113, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{"stall2",    1'b1, 1'b0, 32'h0,  32'h08, 32'h04, 32'h00500113, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"resume",    1'b0, 1'b0, 32'h0,  32'h0C, 32'h08, 32'h00208463, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{"br_stall",  1'b1, 1'b1, 32'h14, 32'h14, 32'h0C, NOP,          1'b0, 1'b0, 1'b0};
    tbl[6] = '{"br_tgt",    1'b0, 1'b0, 32'h0,  32'h18, 32'h14, 32'h00A00313, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{"misalign",  1'b0, 1'b1, 32'h16, 32'h14, 32'h18, NOP,          1'b0, 1'b0, 1'b1};
    tbl[8] = '{"oob_br",    1'b0, 1'b1, 32'h80, 32'h80, 32'h14, NOP,          1'b0, 1'b1, 1'b1};
    tbl[9] = '{"oob_fetch", 1'b0, 1'b0, 32'h0,  32'h84, 32'h80, NOP,          1'b1, 1'b1, 1'b1};

    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_we       = 1'b0;
    imem_waddr    = 5'd0;
    imem_wdata    = 32'h0;
    #1;
    chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);

    // Program loads are issued while reset is held.
    load(5'd0, 32'h00500093);
    load(5'd1, 32'h00500113);
    load(5'd2, 32'h00208463);
    load(5'd5, 32'h00A00313);
    chk_all("reset_hold", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      stall         = tbl[i].stall;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].tgt;
      step();
      chk_all(tbl[i].name, tbl[i].e_pc, tbl[i].e_ifpc, tbl[i].e_instr,
              tbl[i].e_vld, tbl[i].e_oob, tbl[i].e_mis);
    end
    stall        = 1'b0;
    branch_taken = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sticky.pc", pc, 32'h84 + 32'(4 * k));
      chk("sticky.misalign", {31'b0, misalign_err}, 32'h1);
    end

    // Write imem[3] in the same cycle it is fetched: old word captured, new word after rewind.
    branch_taken  = 1'b1;
    branch_target = 32'h0C;
    step();
    branch_taken  = 1'b0;
    chk("rewind1.pc", pc, 32'h0C);
    chk("rewind1.oob", {31'b0, fetch_oob}, 32'h0);
    load(5'd3, 32'h00900293);
    chk_all("wr_same", 32'h10, 32'h0C, NOP, 1'b1, 1'b0, 1'b1);
    branch_taken  = 1'b1;
    branch_target = 32'h0C;
    step();
    branch_taken  = 1'b0;
    chk_all("rewind2", 32'h0C, 32'h10, NOP, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("wr_new", 32'h10, 32'h0C, 32'h00900293, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges while stalled with a redirect pending.
    stall = 1'b1;
    step();
    chk("stall_pre.pc", pc, 32'h10);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rst_held", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0);
    stall        = 1'b0;
    branch_taken = 1'b0;
    #2;
    rst = 1'b0;

    // Memory survives reset: refetch 0..3 including the rewritten word.
    step();
    chk_all("post0", 32'h04, 32'h00, 32'h00500093, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("post1", 32'h08, 32'h04, 32'h00500113, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("post2", 32'h0C, 32'h08, 32'h00208463, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("post3", 32'h10, 32'h0C, 32'h00900293, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
